// File: rtl/bt_cmd_rx.sv
// UART 8N1 receiver and ASCII command decoder (song select, volume pulses) for the BT serial link.
// Optional echo transmitter enabled by defining BT_ECHO_EN; default build holds UART_TXD at 1.
module bt_cmd_rx #(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD      = 9600,
    parameter int NUM_SONGS = 7
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       UART_RXD,
    output logic       UART_TXD,
    output logic [7:0] rxd_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic [2:0] sw,
    output logic       sw_changed,
    output logic       vol_up,
    output logic       vol_down
);

    localparam int CPB = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(CPB + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);
    localparam logic [7:0]    SONG_MAX  = 8'(8'h30 + NUM_SONGS);
    localparam logic [2:0]    SW_LAST   = 3'(NUM_SONGS - 1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    logic            rxd_meta_r;
    logic            rxd_sync_r;
    rx_state_t       rx_state_r;
    logic [CW-1:0]   rx_cnt_r;
    logic [2:0]      rx_bit_r;
    logic [7:0]      rx_shift_r;
    logic            rx_armed_r;
    logic [7:0]      rxd_data_r;
    logic            rx_valid_r;
    logic            frame_err_r;
    logic [2:0]      sw_r;
    logic            sw_changed_r;
    logic            vol_up_r;
    logic            vol_down_r;
    logic [2:0]      sw_nxt_s;
    logic            up_s;
    logic            dn_s;

    // Two-flop synchroniser for the asynchronous serial input (idle high)
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
        end else begin
            rxd_meta_r <= UART_RXD;
            rxd_sync_r <= rxd_meta_r;
        end
    end

    // Receive state machine; rx_armed_r blocks a new frame until the line has been high
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_state_r  <= RX_IDLE;
            rx_cnt_r    <= '0;
            rx_bit_r    <= 3'd0;
            rx_shift_r  <= 8'h00;
            rx_armed_r  <= 1'b0;
            rxd_data_r  <= 8'h00;
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            case (rx_state_r)
                RX_IDLE: begin
                    rx_cnt_r <= '0;
                    rx_bit_r <= 3'd0;
                    if (rxd_sync_r) begin
                        rx_armed_r <= 1'b1;
                    end else if (rx_armed_r) begin
                        rx_armed_r <= 1'b0;
                        rx_state_r <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt_r == HALF_LAST) begin
                        rx_cnt_r   <= '0;
                        rx_state_r <= rxd_sync_r ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_r == BIT_LAST) begin
                        rx_cnt_r   <= '0;
                        rx_shift_r <= {rxd_sync_r, rx_shift_r[7:1]};
                        rx_bit_r   <= rx_bit_r + 3'd1;
                        if (rx_bit_r == 3'd7) begin
                            rx_state_r <= RX_STOP;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_r == BIT_LAST) begin
                        rx_cnt_r   <= '0;
                        rx_state_r <= RX_IDLE;
                        if (rxd_sync_r) begin
                            rxd_data_r <= rx_shift_r;
                            rx_valid_r <= 1'b1;
                        end else begin
                            frame_err_r <= 1'b1;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CW'(1);
                    end
                end
                default: begin
                    rx_state_r <= RX_IDLE;
                end
            endcase
        end
    end

    // Command decode of the byte presented on the rx_valid cycle
    always_comb begin
        sw_nxt_s = sw_r;
        up_s     = 1'b0;
        dn_s     = 1'b0;
        if (rx_valid_r) begin
            if ((rxd_data_r >= 8'h31) && (rxd_data_r <= SONG_MAX)) begin
                sw_nxt_s = 3'(rxd_data_r - 8'h31);
            end else begin
                case (rxd_data_r)
                    8'h4E:   sw_nxt_s = (sw_r == SW_LAST) ? 3'd0 : sw_r + 3'd1;
                    8'h50:   sw_nxt_s = (sw_r == 3'd0) ? SW_LAST : sw_r - 3'd1;
                    8'h55:   up_s = 1'b1;
                    8'h44:   dn_s = 1'b1;
                    default: sw_nxt_s = sw_r;
                endcase
            end
        end else begin
            sw_nxt_s = sw_r;
        end
    end

    // Registered decoder outputs, one clock after rx_valid
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sw_r         <= 3'd0;
            sw_changed_r <= 1'b0;
            vol_up_r     <= 1'b0;
            vol_down_r   <= 1'b0;
        end else begin
            sw_r         <= sw_nxt_s;
            sw_changed_r <= (sw_nxt_s != sw_r);
            vol_up_r     <= up_s;
            vol_down_r   <= dn_s;
        end
    end

    assign rxd_data   = rxd_data_r;
    assign rx_valid   = rx_valid_r;
    assign frame_err  = frame_err_r;
    assign sw         = sw_r;
    assign sw_changed = sw_changed_r;
    assign vol_up     = vol_up_r;
    assign vol_down   = vol_down_r;

`ifdef BT_ECHO_EN
    logic            tx_busy_r;
    logic [8:0]      tx_shift_r;
    logic [3:0]      tx_bits_r;
    logic [CW-1:0]   tx_cnt_r;
    logic            txd_r;
    logic            pend_r;
    logic [7:0]      pend_data_r;
    logic            tx_end_s;

    assign tx_end_s = tx_busy_r && (tx_cnt_r == BIT_LAST) && (tx_bits_r == 4'd9);

    // Echo transmitter with a single overwrite-on-full pending byte
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tx_busy_r   <= 1'b0;
            tx_shift_r  <= 9'h1FF;
            tx_bits_r   <= 4'd0;
            tx_cnt_r    <= '0;
            txd_r       <= 1'b1;
            pend_r      <= 1'b0;
            pend_data_r <= 8'h00;
        end else if (!tx_busy_r || tx_end_s) begin
            if (pend_r) begin
                tx_busy_r   <= 1'b1;
                txd_r       <= 1'b0;
                tx_shift_r  <= {1'b1, pend_data_r};
                tx_bits_r   <= 4'd0;
                tx_cnt_r    <= '0;
                pend_r      <= rx_valid_r;
                pend_data_r <= rx_valid_r ? rxd_data_r : pend_data_r;
            end else if (rx_valid_r) begin
                tx_busy_r  <= 1'b1;
                txd_r      <= 1'b0;
                tx_shift_r <= {1'b1, rxd_data_r};
                tx_bits_r  <= 4'd0;
                tx_cnt_r   <= '0;
            end else begin
                tx_busy_r <= 1'b0;
                txd_r     <= 1'b1;
                tx_cnt_r  <= '0;
            end
        end else begin
            if (rx_valid_r) begin
                pend_r      <= 1'b1;
                pend_data_r <= rxd_data_r;
            end
            if (tx_cnt_r == BIT_LAST) begin
                tx_cnt_r   <= '0;
                txd_r      <= tx_shift_r[0];
                tx_shift_r <= {1'b1, tx_shift_r[8:1]};
                tx_bits_r  <= tx_bits_r + 4'd1;
            end else begin
                tx_cnt_r <= tx_cnt_r + CW'(1);
            end
        end
    end

    assign UART_TXD = txd_r;
`else
    assign UART_TXD = 1'b1;
`endif

endmodule

// File: tb/tb_bt_cmd_rx.sv
// Directed bench for bt_cmd_rx at a scaled bit period (CPB = 32 clocks).
module tb_bt_cmd_rx;

    localparam int CLK_FREQ = 2000000;
    localparam int BAUD     = 62500;
    localparam int CPB      = CLK_FREQ / BAUD;

    logic       CLK;
    logic       RST;
    logic       UART_RXD;
    logic       UART_TXD;
    logic [7:0] rxd_data;
    logic       rx_valid;
    logic       frame_err;
    logic [2:0] sw;
    logic       sw_changed;
    logic       vol_up;
    logic       vol_down;

    int vec_cnt = 0;
    int err_cnt = 0;

    int n_rx = 0, n_ferr = 0, n_swch = 0, n_up = 0, n_dn = 0;
    int lat_bad = 0, wide_bad = 0, both_bad = 0, tx_low = 0;
    int cyc = 0, t_up = 0, t_dn = 0;
    logic [7:0] last_rx = 8'h00;
    logic prev_rxv = 1'b0, prev_up = 1'b0, prev_dn = 1'b0;
    logic prev_swch = 1'b0, prev_ferr = 1'b0, prev_rxv2 = 1'b0;

    bt_cmd_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .NUM_SONGS(7)) dut (
        .CLK(CLK), .RST(RST), .UART_RXD(UART_RXD), .UART_TXD(UART_TXD),
        .rxd_data(rxd_data), .rx_valid(rx_valid), .frame_err(frame_err),
        .sw(sw), .sw_changed(sw_changed), .vol_up(vol_up), .vol_down(vol_down)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse monitor, sampled on the falling edge
    always @(negedge CLK) begin
        cyc++;
        if (rx_valid) begin
            n_rx++;
            last_rx = rxd_data;
        end
        if (frame_err) n_ferr++;
        if (sw_changed) n_swch++;
        if (vol_up) begin
            n_up++;
            t_up = cyc;
        end
        if (vol_down) begin
            n_dn++;
            t_dn = cyc;
        end
        if ((sw_changed || vol_up || vol_down) && !prev_rxv) lat_bad++;
        if ((vol_up && prev_up) || (vol_down && prev_dn) || (sw_changed && prev_swch)
            || (rx_valid && prev_rxv2) || (frame_err && prev_ferr)) wide_bad++;
        if (vol_up && vol_down) both_bad++;
        if (!UART_TXD) tx_low++;
        prev_rxv  = rx_valid;
        prev_rxv2 = rx_valid;
        prev_up   = vol_up;
        prev_dn   = vol_down;
        prev_swch = sw_changed;
        prev_ferr = frame_err;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(posedge CLK);
        UART_RXD = 1'b0;
        repeat (CPB) @(posedge CLK);
        for (int i = 0; i < 8; i++) begin
            UART_RXD = b[i];
            repeat (CPB) @(posedge CLK);
        end
        UART_RXD = stop_bit;
        repeat (CPB) @(posedge CLK);
        UART_RXD = 1'b1;
        repeat (2 * CPB) @(posedge CLK);
    endtask

    task automatic echo_capture(input logic [9:0] exp_bits);
        int t;
        t = 0;
        while (UART_TXD && t < 20 * CPB) begin
            @(negedge CLK);
            t++;
        end
        chk("echo_start", {31'd0, UART_TXD}, 32'd0);
        repeat (CPB / 2) @(negedge CLK);
        for (int i = 0; i < 10; i++) begin
            chk("echo_bit", {31'd0, UART_TXD}, {31'd0, exp_bits[i]});
            repeat (CPB) @(negedge CLK);
        end
    endtask

    initial begin
        int gap;
        logic [9:0] echo33;
        RST      = 1'b0;
        UART_RXD = 1'b1;
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        chk("rst_sw", {29'd0, sw}, 32'd0);
        chk("rst_pulses", {27'd0, rx_valid, frame_err, sw_changed, vol_up, vol_down}, 32'd0);
        chk("rst_txd", {31'd0, UART_TXD}, 32'd1);
        chk("rst_rxd_data", {24'd0, rxd_data}, 32'd0);
        RST = 1'b1;
        repeat (200) @(posedge CLK);
        @(negedge CLK);
        chk("idle_sw", {29'd0, sw}, 32'd0);
        chk("idle_pulses", n_rx + n_ferr + n_swch + n_up + n_dn, 32'd0);

        send_byte(8'h35, 1'b1);
        chk("sel5_rx", n_rx, 32'd1);
        chk("sel5_data", {24'd0, last_rx}, 32'h35);
        chk("sel5_sw", {29'd0, sw}, 32'd4);
        chk("sel5_swch", n_swch, 32'd1);
        send_byte(8'h35, 1'b1);
        chk("sel5b_rx", n_rx, 32'd2);
        chk("sel5b_sw", {29'd0, sw}, 32'd4);
        chk("sel5b_swch", n_swch, 32'd1);

        send_byte(8'h37, 1'b1);
        chk("sel7_sw", {29'd0, sw}, 32'd6);
        chk("sel7_swch", n_swch, 32'd2);
        send_byte(8'h4E, 1'b1);
        chk("next_wrap_sw", {29'd0, sw}, 32'd0);
        chk("next_wrap_swch", n_swch, 32'd3);
        send_byte(8'h50, 1'b1);
        chk("prev_wrap_sw", {29'd0, sw}, 32'd6);
        chk("prev_wrap_swch", n_swch, 32'd4);

        send_byte(8'h55, 1'b1);
        send_byte(8'h44, 1'b1);
        chk("vol_up_cnt", n_up, 32'd1);
        chk("vol_dn_cnt", n_dn, 32'd1);
        gap = t_dn - t_up;
        chk("vol_gap", {31'd0, (gap >= 10 * CPB)}, 32'd1);
        chk("vol_sw", {29'd0, sw}, 32'd6);
        chk("vol_swch", n_swch, 32'd4);
        chk("vol_rx", n_rx, 32'd7);

        @(posedge CLK);
        UART_RXD = 1'b0;
        repeat (CPB / 2 - 6) @(posedge CLK);
        UART_RXD = 1'b1;
        repeat (3 * CPB) @(posedge CLK);
        chk("glitch_pulses", n_rx + n_ferr, 32'd7);

        send_byte(8'h32, 1'b0);
        chk("ferr_cnt", n_ferr, 32'd1);
        chk("ferr_rx", n_rx, 32'd7);
        chk("ferr_data", {24'd0, rxd_data}, 32'h44);
        chk("ferr_sw", {29'd0, sw}, 32'd6);

        @(posedge CLK);
        UART_RXD = 1'b0;
        repeat (CPB) @(posedge CLK);
        for (int i = 0; i < 4; i++) begin
            UART_RXD = (i == 0) ? 1'b1 : 1'b0;
            repeat (CPB) @(posedge CLK);
        end
        UART_RXD = 1'b1;
        repeat (CPB / 2) @(posedge CLK);
        RST = 1'b0;
        repeat (5) @(posedge CLK);
        RST = 1'b1;
        repeat (2 * CPB) @(posedge CLK);
        @(negedge CLK);
        chk("midrst_rx", n_rx, 32'd7);
        chk("midrst_sw", {29'd0, sw}, 32'd0);

        echo33 = 10'b10_0110_0110;
`ifdef BT_ECHO_EN
        fork
            send_byte(8'h33, 1'b1);
            echo_capture(echo33);
        join
`else
        send_byte(8'h33, 1'b1);
`endif
        chk("midrst_rx2", n_rx, 32'd8);
        chk("midrst_data", {24'd0, last_rx}, 32'h33);
        chk("midrst_sw2", {29'd0, sw}, 32'd2);
        chk("midrst_swch", n_swch, 32'd5);

        chk("latency", lat_bad, 32'd0);
        chk("pulse_width", wide_bad, 32'd0);
        chk("vol_exclusive", both_bad, 32'd0);
`ifndef BT_ECHO_EN
        chk("txd_idle", tx_low, 32'd0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/bt_cmd_rx.md
Name: bt_cmd_rx

Overview:
UART receiver and command decoder for the Bluetooth module's serial link. Recovers 8N1 bytes from UART_RXD and turns ASCII commands into a song index and one-cycle volume up/down pulses. It sits directly upstream of the player core, which consumes sw, vol_up and vol_down. Runs on the undivided 100 MHz system clock.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD, 9600, UART bit rate
NUM_SONGS, 7, number of valid song indices (0..NUM_SONGS-1), 2..8

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-low reset
UART_RXD  in  1  serial input from the BT module, idle high, asynchronous to CLK
UART_TXD  out  1  serial output to the BT module
rxd_data  out  8  last correctly framed byte
rx_valid  out  1  one-cycle pulse when rxd_data updates
frame_err  out  1  one-cycle pulse on a bad stop bit
sw  out  3  current song index
sw_changed  out  1  one-cycle pulse when sw takes a new value
vol_up  out  1  one-cycle volume-up pulse
vol_down  out  1  one-cycle volume-down pulse

Behaviour:
- Reset is asynchronous, active-low on RST. All outputs reset to 0 except UART_TXD, which resets to 1. The state machine returns to IDLE and all counters clear.
- Reset asserted mid-frame aborts the frame. No pulse is generated for that frame.
- Bit period: CPB = CLK_FREQ/BAUD, integer division. The default is 10416 clocks.
- UART_RXD passes through a 2-FF synchroniser before any use. All references below are to the synchronised signal.
- RX state machine:
  - IDLE: wait for the synchronised line to go low, then go to START and clear the bit-time counter.
  - START: after CPB/2 clocks, sample the line. Low goes to DATA. High is a glitch and returns to IDLE with no pulse.
  - DATA: sample every CPB clocks. 8 bits, LSB first, shifted into a holding register.
  - STOP: sample after CPB clocks. High: load rxd_data and pulse rx_valid for 1 cycle on the clock after the sample. Low: pulse frame_err for 1 cycle, leave rxd_data unchanged, and issue no decode. Either way, go to IDLE.
  - If the line is still low on returning to IDLE (break condition), no new frame starts until the line has been seen high.
- Command decode happens on the rx_valid cycle. Decoded outputs register one cycle later, so sw, sw_changed, vol_up and vol_down appear 1 clock after rx_valid.
  - 0x31..0x30+NUM_SONGS ('1'..'7' by default): sw = byte-0x31.
  - 0x4E 'N': sw = (sw == NUM_SONGS-1) ? 0 : sw+1.
  - 0x50 'P': sw = (sw == 0) ? NUM_SONGS-1 : sw-1.
  - 0x55 'U': vol_up = 1 for one cycle.
  - 0x44 'D': vol_down = 1 for one cycle.
  - Any other byte: ignored, but rx_valid still pulses.
- sw_changed pulses only when the new sw differs from the old sw. Selecting the current song gives no pulse.
- vol_up and vol_down are never high in the same cycle.
- Back-to-back bytes: the minimum spacing between rx_valid pulses is 10·CPB clocks, so decode never overlaps.
- Without the optional feature, UART_TXD is held at 1.

Optional Feature:
BT_ECHO_EN
- Defined: adds an 8N1 transmitter at the same CPB. Every correctly framed received byte is echoed on UART_TXD.
- TX starts on the clock after rx_valid and runs start bit, 8 data bits LSB first, then the stop bit.
- A received byte that arrives while TX is busy is held in a 1-entry buffer and sent right after the current frame. A third byte overwrites that buffer entry.
- Frame errors are not echoed.
- Not defined: no TX logic is built and UART_TXD is constant 1.

Test Plan:
- Reset: hold RST=0 for 10 clocks with UART_RXD=1. Required: sw=0, all pulses 0, UART_TXD=1. Release RST; outputs stay the same for 20000 clocks.
- Song select: send 0x35 ('5'). Required: rx_valid pulse with rxd_data=0x35, then 1 clock later sw=4 and a sw_changed pulse. Send 0x35 again: sw stays 4 and there is no sw_changed.
- Wrap: from sw=6 send 'N' (0x4E), expect sw=0. Then send 'P' (0x50), expect sw=6. Each step pulses sw_changed.
- Volume: send 'U' (0x55), then 'D' (0x44), back to back. Required: exactly one vol_up pulse and one vol_down pulse, each 1 cycle wide, at least 10·CPB clocks apart, and sw unchanged.
- Errors: drive a 2000-clock low glitch on UART_RXD, which is shorter than CPB/2. Required: no pulse. Then send a frame with stop bit = 0. Required: one frame_err pulse, rxd_data unchanged, no decode.
- Reset mid-frame: assert RST during data bit 4 of 0x31, release it, then send 0x33. Required: only the 0x33 is decoded (sw=2). With BT_ECHO_EN defined, UART_TXD also replays 0x33 as 0,1,1,0,0,1,1,0,0,1 at CPB spacing.
